// File: rtl/tmds_word_aligner.sv
// rtl/tmds_word_aligner.sv - TMDS receive word aligner: finds control-token bit offset and locks to it
module tmds_word_aligner #(
    parameter int LOCK_COUNT   = 8,
    parameter int SEARCH_DWELL = 2048,
    parameter int LOSS_DWELL   = 4096
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic [9:0] raw_in,
    input  logic       realign,
    output logic [9:0] data_out,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int IDLE_MAX = (SEARCH_DWELL > LOSS_DWELL) ? SEARCH_DWELL : LOSS_DWELL;
    localparam int MW       = $clog2(LOCK_COUNT + 1);
    localparam int IW       = $clog2(IDLE_MAX + 1);

    localparam logic [MW-1:0] LOCK_TGT   = MW'(LOCK_COUNT);
    localparam logic [IW-1:0] SEARCH_TGT = IW'(SEARCH_DWELL);
    localparam logic [IW-1:0] LOSS_TGT   = IW'(LOSS_DWELL);

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state;
    logic [9:0]    raw_prev;
    logic [MW-1:0] match_cnt;
    logic [IW-1:0] idle_cnt;

    logic [19:0]   pair;
    logic [9:0]    win;
    logic          tok_hit;
    logic [1:0]    tok_ctrl;
    logic [MW-1:0] match_nxt;
    logic [IW-1:0] idle_nxt;
    logic [3:0]    offset_inc;

    assign pair       = {raw_in, raw_prev};
    assign match_nxt  = match_cnt + MW'(1);
    assign idle_nxt   = idle_cnt + IW'(1);
    assign offset_inc = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

    // Select the 10-bit window starting at the current bit offset
    always_comb begin
        win = pair[9:0];
        for (int i = 1; i < 10; i++) begin
            if (offset == 4'(i)) begin
                win = pair[i +: 10];
            end
        end
    end

    // Recognise the four TMDS control tokens and recover {C1,C0}
    always_comb begin
        tok_hit  = 1'b1;
        tok_ctrl = 2'b00;
        case (win)
            10'b1101010100: tok_ctrl = 2'b00;
            10'b0010101011: tok_ctrl = 2'b01;
            10'b0101010100: tok_ctrl = 2'b10;
            10'b1010101011: tok_ctrl = 2'b11;
            default:        tok_hit  = 1'b0;
        endcase
    end

    // Registered symbol path; driven regardless of lock so downstream gates on locked
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            raw_prev <= 10'd0;
            data_out <= 10'd0;
            is_ctrl  <= 1'b0;
            ctrl     <= 2'b00;
        end else begin
            raw_prev <= raw_in;
            data_out <= win;
            is_ctrl  <= tok_hit;
            ctrl     <= tok_hit ? tok_ctrl : 2'b00;
        end
    end

    // Search/lock state machine; realign overrides every other event in the same cycle
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            offset    <= 4'd0;
            match_cnt <= '0;
            idle_cnt  <= '0;
        end else if (realign) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            match_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (tok_hit) begin
                        idle_cnt <= '0;
                        if (match_nxt == LOCK_TGT) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= match_nxt;
                        end
                    end else begin
                        match_cnt <= '0;
                        if (idle_nxt == SEARCH_TGT) begin
                            offset   <= offset_inc;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_nxt;
                        end
                    end
                end
                LOCKED: begin
                    if (tok_hit) begin
                        idle_cnt <= '0;
                    end else if (idle_nxt == LOSS_TGT) begin
                        state     <= SEARCH;
                        locked    <= 1'b0;
                        offset    <= offset_inc;
                        idle_cnt  <= '0;
                        match_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_nxt;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_word_aligner.sv
// tb/tb_tmds_word_aligner.sv - scoreboard bench for tmds_word_aligner
module tb_tmds_word_aligner;

    localparam int LC = 8;
    localparam int SD = 16;
    localparam int LD = 32;

    logic       clk_pixel = 1'b0;
    logic       reset_n;
    logic [9:0] raw_in;
    logic       realign;
    logic [9:0] data_out;
    logic       is_ctrl;
    logic [1:0] ctrl;
    logic       locked;
    logic [3:0] offset;

    always #5 clk_pixel = ~clk_pixel;

    tmds_word_aligner #(
        .LOCK_COUNT  (LC),
        .SEARCH_DWELL(SD),
        .LOSS_DWELL  (LD)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset_n  (reset_n),
        .raw_in   (raw_in),
        .realign  (realign),
        .data_out (data_out),
        .is_ctrl  (is_ctrl),
        .ctrl     (ctrl),
        .locked   (locked),
        .offset   (offset)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [9:0] d;
        logic       c;
        logic [1:0] k;
        logic       l;
        logic [3:0] o;
    } exp_t;

    exp_t sb[$];
    bit   sq[$];

    logic [9:0] tokens[4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    // reference model state: bit-stream view of the channel
    logic [9:0] m_prev;
    int         m_off;
    bit         m_locked;
    int         m_run_tok;
    int         m_run_idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int tok_index(input logic [9:0] w);
        for (int i = 0; i < 4; i++) begin
            if (tokens[i] == w) return i;
        end
        return -1;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] v;
        do v = 10'($urandom_range(0, 1023)); while (tok_index(v) >= 0);
        return v;
    endfunction

    task automatic model_reset();
        m_prev     = 10'd0;
        m_off      = 0;
        m_locked   = 1'b0;
        m_run_tok  = 0;
        m_run_idle = 0;
    endtask

    task automatic model_step(input logic [9:0] raw, input bit rl);
        int   stream;
        int   idx;
        exp_t e;
        stream = (int'(raw) << 10) | int'(m_prev);
        e.d = 10'((stream >> m_off) & 1023);
        idx = tok_index(e.d);
        e.c = (idx >= 0);
        e.k = (idx >= 0) ? 2'(idx) : 2'd0;
        if (rl) begin
            m_locked   = 1'b0;
            m_run_tok  = 0;
            m_run_idle = 0;
        end else if (!m_locked) begin
            if (idx >= 0) begin
                m_run_tok++;
                m_run_idle = 0;
                if (m_run_tok == LC) begin
                    m_locked  = 1'b1;
                    m_run_tok = 0;
                end
            end else begin
                m_run_tok = 0;
                m_run_idle++;
                if (m_run_idle == SD) begin
                    m_off      = (m_off + 1) % 10;
                    m_run_idle = 0;
                end
            end
        end else begin
            if (idx >= 0) begin
                m_run_idle = 0;
            end else begin
                m_run_idle++;
                if (m_run_idle == LD) begin
                    m_locked   = 1'b0;
                    m_off      = (m_off + 1) % 10;
                    m_run_idle = 0;
                    m_run_tok  = 0;
                end
            end
        end
        m_prev = raw;
        e.l = m_locked;
        e.o = 4'(m_off);
        sb.push_back(e);
    endtask

    task automatic drive_word(input logic [9:0] w, input bit rl);
        raw_in  = w;
        realign = rl;
        model_step(w, rl);
        @(posedge clk_pixel);
        @(negedge clk_pixel);
        realign = 1'b0;
    endtask

    // symbols are laid on the wire starting 3 bits into each raw word
    task automatic send_sym(input logic [9:0] sym, input bit rl);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) sq.push_back(sym[i]);
        for (int i = 0; i < 10; i++) w[i] = sq.pop_front();
        drive_word(w, rl);
    endtask

    task automatic prime_stream();
        sq.delete();
        for (int i = 7; i < 10; i++) sq.push_back(tokens[0][i]);
    endtask

    // monitor: compare every output against the queued expectation after each edge
    always @(posedge clk_pixel) begin
        exp_t e;
        #1;
        if (reset_n === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_data_out", 32'(data_out), 32'(e.d));
            chk("sb_is_ctrl",  32'(is_ctrl),  32'(e.c));
            chk("sb_ctrl",     32'(ctrl),     32'(e.k));
            chk("sb_locked",   32'(locked),   32'(e.l));
            chk("sb_offset",   32'(offset),   32'(e.o));
        end
    end

    initial begin
        int k;
        reset_n = 1'b0;
        realign = 1'b0;
        raw_in  = 10'd0;
        model_reset();
        prime_stream();

        // reset with random raw data and running clock
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_pixel);
            raw_in = 10'($urandom_range(0, 1023));
        end
        @(negedge clk_pixel);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_is_ctrl",  32'(is_ctrl), 0);
        chk("rst_ctrl",     32'(ctrl), 0);
        chk("rst_locked",   32'(locked), 0);
        chk("rst_offset",   32'(offset), 0);
        reset_n = 1'b1;
        #1;
        chk("rel_offset", 32'(offset), 0);
        chk("rel_locked", 32'(locked), 0);

        // acquisition: token stream at bit phase 3
        k = 0;
        while (locked !== 1'b1 && k < 200) begin
            send_sym(tokens[0], 1'b0);
            k++;
        end
        chk("acq_words",  32'(k), 56);
        chk("acq_locked", 32'(locked), 1);
        chk("acq_offset", 32'(offset), 3);
        send_sym(tokens[0], 1'b0);
        chk("acq_data_out", 32'(data_out), 32'(tokens[0]));
        chk("acq_is_ctrl",  32'(is_ctrl), 1);
        chk("acq_ctrl",     32'(ctrl), 0);

        // decode of each token then a data word
        send_sym(tokens[1], 1'b0);
        send_sym(tokens[2], 1'b0);
        chk("dec1_data", 32'(data_out), 32'(tokens[1]));
        chk("dec1_ctrl", 32'(ctrl), 1);
        send_sym(tokens[3], 1'b0);
        chk("dec2_ctrl", 32'(ctrl), 2);
        send_sym(tokens[0], 1'b0);
        chk("dec3_ctrl", 32'(ctrl), 3);
        chk("dec3_is_ctrl", 32'(is_ctrl), 1);
        send_sym(rand_data(), 1'b0);
        chk("dec0_ctrl", 32'(ctrl), 0);
        send_sym(rand_data(), 1'b0);
        chk("dec_data_is_ctrl", 32'(is_ctrl), 0);
        chk("dec_data_ctrl",    32'(ctrl), 0);
        chk("dec_still_locked", 32'(locked), 1);

        // realign with a token, then relock
        send_sym(tokens[0], 1'b1);
        chk("ra_locked", 32'(locked), 0);
        chk("ra_offset", 32'(offset), 3);
        k = 0;
        while (locked !== 1'b1 && k < 40) begin
            send_sym(tokens[0], 1'b0);
            k++;
        end
        chk("ra_relock_words", 32'(k), 8);

        // hold through 20 data words, then lose lock after 32 more
        for (int i = 0; i < 20; i++) send_sym(rand_data(), 1'b0);
        send_sym(tokens[0], 1'b0);
        chk("hold_locked", 32'(locked), 1);
        k = 0;
        while (locked !== 1'b0 && k < 60) begin
            send_sym(rand_data(), 1'b0);
            k++;
        end
        chk("loss_words",  32'(k), 33);
        chk("loss_offset", 32'(offset), 4);

        // randomized traffic: token-heavy symbols, occasional realign
        for (int i = 0; i < 600; i++) begin
            logic [9:0] s;
            s = ($urandom_range(0, 3) != 0) ? tokens[$urandom_range(0, 3)] : rand_data();
            send_sym(s, $urandom_range(0, 99) == 0);
        end

        // synchronous reset, then search to offset 2 and reset asynchronously
        reset_n = 1'b0;
        @(negedge clk_pixel);
        reset_n = 1'b1;
        model_reset();
        prime_stream();
        k = 0;
        while (m_off != 2 && k < 100) begin
            send_sym(rand_data(), 1'b0);
            k++;
        end
        chk("ar_pre_offset", 32'(offset), 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_offset",   32'(offset), 0);
        chk("ar_locked",   32'(locked), 0);
        chk("ar_data_out", 32'(data_out), 0);
        @(negedge clk_pixel);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) send_sym(rand_data(), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
